mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles per multiply.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles per divide.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to execute op.
REQ-006 SHALL have port op  input  4  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO, 6=MFHI, 7=MFLO, others=NOP.
REQ-007 SHALL have port A  input  32  rs operand (forwarded register-file read data).
REQ-008 SHALL have port B  input  32  rt operand (forwarded register-file read data).
REQ-009 SHALL have port busy  output  1  multi-cycle operation in progress.
REQ-010 SHALL have port HI  output  32  current HI register.
REQ-011 SHALL have port LO  output  32  current LO register.
REQ-012 SHALL have port result  output  32  MFHI/MFLO read data for register-file write-back.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV with a down-counter.
REQ-014 SHALL, in IDLE with start=1 and op in 0..3, latch A, B and op, load the counter, and enter MUL or DIV at that edge.
REQ-015 SHALL assert busy for exactly MULT_CYCLES (MUL) or DIV_CYCLES (DIV) cycles, starting the cycle after the start edge.
REQ-016 SHALL write HI/LO on the edge that ends the last busy cycle, then return to IDLE with busy=0.
REQ-017 SHALL ignore start with any op while busy=1; the hazard unit is required to stall on (start & op in 0..7) | busy.
REQ-018 SHALL, for MULT, form the signed 64-bit product with HI=[63:32] and LO=[31:0]; for MULTU, the unsigned product.
REQ-019 SHALL, for DIV/DIVU with B!=0, set LO=quotient truncated toward zero and HI=remainder with the sign of the dividend.
REQ-020 SHALL, for signed 0x80000000 / 0xFFFFFFFF, set LO=0x80000000 and HI=0.
REQ-021 SHALL, for MTHI/MTLO with start=1 in IDLE, write A into HI/LO at that edge without asserting busy.
REQ-022 SHALL drive result combinationally: HI when op=MFHI, LO when op=MFLO, 0 otherwise; result is independent of busy and start.
REQ-023 SHALL compute from the latched operands only; A/B changes during busy SHALL NOT affect the outcome.
REQ-024 SHALL leave HI/LO unchanged during busy until the completion edge.

Reset
REQ-025 SHALL, while reset=1 and independent of clk, force state=IDLE, counter=0, busy=0, HI=0, LO=0, and latched operands=0.
REQ-026 SHALL abort an in-flight operation on reset without any HI/LO update; the first start is accepted on the first rising edge after reset deasserts.

Configuration
REQ-027 SHALL support macro MDU_DIV0_KEEP_EN.
REQ-028 SHALL, with MDU_DIV0_KEEP_EN defined, run DIV/DIVU with B=0 for the full DIV_CYCLES and leave HI/LO unchanged at completion.
REQ-029 SHALL, without MDU_DIV0_KEEP_EN, complete DIV/DIVU with B=0 by writing LO=0xFFFFFFFF and HI=dividend.

Verification
REQ-030 SHALL cover: MULT A=0xFFFFFFFE (-2), B=3 -> busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-031 SHALL cover: DIV A=0xFFFFFFF9 (-7), B=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-032 SHALL cover: MTHI A=0x12345678, then MFHI on the next cycle -> busy stays 0 and result=0x12345678; a MTLO with start=1 issued mid-MULT -> ignored, LO is set only by the MULT.
REQ-033 SHALL cover: reset asserted asynchronously at busy cycle 3 of a DIV -> busy=0, HI=LO=0 immediately, and no write after reset releases.
REQ-034 SHALL cover: DIVU A=0x00000009, B=0 with HI=LO=0x0000AAAA beforehand -> HI=LO=0x0000AAAA with MDU_DIV0_KEEP_EN defined; HI=0x00000009, LO=0xFFFFFFFF without it.
REQ-035 SHALL cover: start a MULT, then toggle A/B every cycle during busy -> result matches the operands captured at the start edge.

Source files
------------

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers. Multiplies and divides run for a fixed number of busy cycles.
// Define MDU_DIV0_KEEP_EN so that a divide by zero leaves HI/LO untouched instead of writing LO=all-ones, HI=dividend.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] result
);

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MTHI  = 4'd4;
    localparam logic [3:0] OP_MTLO  = 4'd5;
    localparam logic [3:0] OP_MFHI  = 4'd6;
    localparam logic [3:0] OP_MFLO  = 4'd7;

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        a_q, a_d, b_q, b_d;
    logic [3:0]         op_q, op_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;
    logic [63:0]        mul_res, div_res;

    // Sign-extending both operands to 64 bits makes the truncated 64x64 product exact for either signedness.
    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b, input logic is_signed);
        logic signed [63:0] sa, sb;
        sa = is_signed ? {{32{a[31]}}, a} : {32'b0, a};
        sb = is_signed ? {{32{b[31]}}, b} : {32'b0, b};
        return sa * sb;
    endfunction

    // Magnitude division then sign fix-up: truncates toward zero, remainder follows the dividend,
    // and 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0. Returns {rem, quo}.
    function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b, input logic is_signed);
        logic        neg_a, neg_b;
        logic [31:0] ua, ub, uq, ur;
        neg_a = is_signed & a[31];
        neg_b = is_signed & b[31];
        ua    = neg_a ? -a : a;
        ub    = neg_b ? -b : b;
        if (ub == 32'd0) ub = 32'd1;
        uq    = ua / ub;
        ur    = ua % ub;
        return {(neg_a ? -ur : ur), ((neg_a ^ neg_b) ? -uq : uq)};
    endfunction

    assign mul_res = mul64(a_q, b_q, op_q == OP_MULT);
    assign div_res = div64(a_q, b_q, op_q == OP_DIV);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            a_d     = A;
                            b_d     = B;
                            op_d    = op;
                            cnt_d   = CNT_W'(MULT_CYCLES - 1);
                            state_d = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            a_d     = A;
                            b_d     = B;
                            op_d    = op;
                            cnt_d   = CNT_W'(DIV_CYCLES - 1);
                            state_d = S_DIV;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (cnt_q == '0) begin
                    hi_d    = mul_res[63:32];
                    lo_d    = mul_res[31:0];
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DIV: begin
                if (cnt_q == '0) begin
                    if (b_q == 32'd0) begin
`ifdef MDU_DIV0_KEEP_EN
                        hi_d = hi_q;
                        lo_d = lo_q;
`else
                        hi_d = a_q;
                        lo_d = 32'hFFFF_FFFF;
`endif
                    end else begin
                        hi_d = div_res[63:32];
                        lo_d = div_res[31:0];
                    end
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign HI   = hi_q;
    assign LO   = lo_q;

    always_comb begin
        case (op)
            OP_MFHI: result = hi_q;
            OP_MFLO: result = lo_q;
            default: result = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: multiply/divide results and latency, moves to/from HI/LO, reset abort, divide by zero.
module tb_mdu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'hF;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy;
    logic [31:0] HI, LO, result;

    int n_cmp = 0;
    int n_bad = 0;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .HI(HI), .LO(LO), .result(result)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        op    = 4'hF;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 64) begin
            n++;
            tick();
        end
    endtask

    task automatic run(input string tag, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int cyc, input logic [31:0] ehi, input logic [31:0] elo);
        logic [31:0] hi0, lo0;
        int n;
        hi0 = HI;
        lo0 = LO;
        issue(o, a, b);
        check({tag, " HI held"}, HI, hi0);
        check({tag, " LO held"}, LO, lo0);
        wait_idle(n);
        check({tag, " busy cycles"}, 32'(n), 32'(cyc));
        check({tag, " HI"}, HI, ehi);
        check({tag, " LO"}, LO, elo);
    endtask

    initial begin
        int n;
        #1 reset = 1'b1;
        #1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset HI", HI, 32'd0);
        check("reset LO", LO, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        run("MULT -2*3", 4'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run("MULTU fffffffe*3", 4'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
        run("DIV -7/2", 4'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run("DIV min/-1", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
        run("DIV 7/-2", 4'd2, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
        run("DIVU 100/7", 4'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14);

        // Moves to HI/LO and reads back through result.
        issue(4'd4, 32'h1234_5678, 32'd0);
        check("MTHI busy", 32'(busy), 32'd0);
        check("MTHI HI", HI, 32'h1234_5678);
        op = 4'd6;
        #1;
        check("MFHI result", result, 32'h1234_5678);
        op = 4'hF;
        issue(4'd5, 32'h0000_0055, 32'd0);
        op = 4'd7;
        #1;
        check("MFLO result", result, 32'h0000_0055);
        op = 4'd9;
        #1;
        check("NOP result", result, 32'd0);
        op = 4'hF;

        // MTLO issued while a MULT is busy must be dropped.
        issue(4'd0, 32'd7, 32'd6);
        tick();
        op    = 4'd5;
        A     = 32'hDEAD_BEEF;
        start = 1'b1;
        tick();
        start = 1'b0;
        op    = 4'hF;
        check("mid-MULT MTLO busy", 32'(busy), 32'd1);
        check("mid-MULT MTLO LO", LO, 32'h0000_0055);
        wait_idle(n);
        check("mid-MULT HI", HI, 32'd0);
        check("mid-MULT LO", LO, 32'd42);

        // Operand changes during busy must not reach the result.
        op    = 4'd1;
        A     = 32'h0001_0000;
        B     = 32'h0001_0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        op    = 4'hF;
        for (int i = 0; i < 8 && busy; i++) begin
            A = $urandom;
            B = $urandom;
            tick();
        end
        check("toggle busy done", 32'(busy), 32'd0);
        check("toggle HI", HI, 32'd1);
        check("toggle LO", LO, 32'd0);

        // Asynchronous reset during a DIV aborts with no later write.
        issue(4'd4, 32'h0000_1111, 32'd0);
        issue(4'd5, 32'h0000_2222, 32'd0);
        issue(4'd3, 32'd100, 32'd7);
        tick();
        tick();
        #1 reset = 1'b1;
        #1;
        check("async rst busy", 32'(busy), 32'd0);
        check("async rst HI", HI, 32'd0);
        check("async rst LO", LO, 32'd0);
        tick();
        #2 reset = 1'b0;
        repeat (12) tick();
        check("post-rst busy", 32'(busy), 32'd0);
        check("post-rst HI", HI, 32'd0);
        check("post-rst LO", LO, 32'd0);
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        op    = 4'd5;
        A     = 32'h0000_0077;
        start = 1'b1;
        tick();
        start = 1'b0;
        op    = 4'hF;
        check("first start after rst", LO, 32'h0000_0077);

        // Divide by zero.
        issue(4'd4, 32'h0000_AAAA, 32'd0);
        issue(4'd5, 32'h0000_AAAA, 32'd0);
`ifdef MDU_DIV0_KEEP_EN
        run("DIVU 9/0", 4'd3, 32'd9, 32'd0, 10, 32'h0000_AAAA, 32'h0000_AAAA);
`else
        run("DIVU 9/0", 4'd3, 32'd9, 32'd0, 10, 32'h0000_0009, 32'hFFFF_FFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
